// File: rtl/sub_pkg.sv
// Shared types and sizing helpers for the serial subtractor datapath.
package sub_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // The slice counter needs to hold L = width / bits_per_cycle.
  function automatic int cnt_width(input int width, input int bits_per_cycle);
    return $clog2(width / bits_per_cycle + 1);
  endfunction

endpackage

// File: rtl/full_sub_slice.sv
// Combinational N-bit ripple full subtractor: d = x - y - c_in, c_out is the borrow out.
module full_sub_slice #(
  parameter int N = 1
) (
  input  logic [N-1:0] x,
  input  logic [N-1:0] y,
  input  logic         c_in,
  output logic [N-1:0] d,
  output logic         c_out
);

  logic [N:0] c;

  always_comb begin
    c    = '0;
    d    = '0;
    c[0] = c_in;
    for (int i = 0; i < N; i++) begin
      d[i]   = x[i] ^ y[i] ^ c[i];
      c[i+1] = (~x[i] & y[i]) | (~(x[i] ^ y[i]) & c[i]);
    end
  end

  assign c_out = c[N];

endmodule

// File: rtl/serial_subtractor.sv
// Multi-cycle a - b - bin, BITS_PER_CYCLE bits per clock, LSB slice first, with start/done handshake.
module serial_subtractor
  import sub_pkg::*;
#(
  parameter int WIDTH          = 8,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf,
  output logic             zero
);

  localparam int L  = WIDTH / BITS_PER_CYCLE;
  localparam int CW = cnt_width(WIDTH, BITS_PER_CYCLE);
  localparam logic [CW-1:0] LAST_SLICE = CW'(L - 1);

  state_t                    state;
  logic [WIDTH-1:0]          a_sh;
  logic [WIDTH-1:0]          b_sh;
  logic [WIDTH-1:0]          part;
  logic                      borrow;
  logic                      a_msb;
  logic                      b_msb;
  logic [CW-1:0]             cnt;
  logic [BITS_PER_CYCLE-1:0] slice_d;
  logic                      slice_bout;
  logic [WIDTH-1:0]          next_part;

  full_sub_slice #(.N(BITS_PER_CYCLE)) u_slice (
    .x     (a_sh[BITS_PER_CYCLE-1:0]),
    .y     (b_sh[BITS_PER_CYCLE-1:0]),
    .c_in  (borrow),
    .d     (slice_d),
    .c_out (slice_bout)
  );

  // Each new slice enters at the top so after L slices the word is right-aligned.
  assign next_part = (part >> BITS_PER_CYCLE) | (WIDTH'(slice_d) << (WIDTH - BITS_PER_CYCLE));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      a_sh   <= '0;
      b_sh   <= '0;
      part   <= '0;
      borrow <= 1'b0;
      a_msb  <= 1'b0;
      b_msb  <= 1'b0;
      cnt    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      diff   <= '0;
      bout   <= 1'b0;
      ovf    <= 1'b0;
      zero   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            a_sh   <= a;
            b_sh   <= b;
            borrow <= bin;
            a_msb  <= a[WIDTH-1];
            b_msb  <= b[WIDTH-1];
            part   <= '0;
            cnt    <= '0;
            busy   <= 1'b1;
            state  <= RUN;
          end
        end
        RUN: begin
          a_sh   <= a_sh >> BITS_PER_CYCLE;
          b_sh   <= b_sh >> BITS_PER_CYCLE;
          part   <= next_part;
          borrow <= slice_bout;
          cnt    <= cnt + CW'(1);
          // Result registers only change here, so they never expose partial sums.
          if (cnt == LAST_SLICE) begin
            diff  <= next_part;
            bout  <= slice_bout;
            ovf   <= (a_msb ^ b_msb) & (a_msb ^ next_part[WIDTH-1]);
            zero  <= (next_part == '0);
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench: three subtractor configurations (8/1, 16/4, 16/16) checked against a reference model.
module tb_serial_subtractor;

  typedef struct packed {
    logic [15:0] diff;
    logic        bout;
    logic        ovf;
    logic        zero;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  start_v = '0;
  logic [15:0] a_v [3];
  logic [15:0] b_v [3];
  logic [2:0]  bin_v = '0;
  logic [2:0]  busy_v, done_v, bout_v, ovf_v, zero_v;
  logic [7:0]  diff8;
  logic [15:0] diff16n, diff16w;
  logic [15:0] diff_v [3];

  int n_compared   = 0;
  int n_mismatched = 0;

  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];

  always #5 clk = ~clk;

  assign diff_v[0] = {8'h00, diff8};
  assign diff_v[1] = diff16n;
  assign diff_v[2] = diff16w;

  serial_subtractor #(.WIDTH(8), .BITS_PER_CYCLE(1)) dut8 (
    .clk(clk), .rst(rst), .start(start_v[0]), .a(a_v[0][7:0]), .b(b_v[0][7:0]), .bin(bin_v[0]),
    .busy(busy_v[0]), .done(done_v[0]), .diff(diff8), .bout(bout_v[0]), .ovf(ovf_v[0]), .zero(zero_v[0])
  );

  serial_subtractor #(.WIDTH(16), .BITS_PER_CYCLE(4)) dut16n (
    .clk(clk), .rst(rst), .start(start_v[1]), .a(a_v[1]), .b(b_v[1]), .bin(bin_v[1]),
    .busy(busy_v[1]), .done(done_v[1]), .diff(diff16n), .bout(bout_v[1]), .ovf(ovf_v[1]), .zero(zero_v[1])
  );

  serial_subtractor #(.WIDTH(16), .BITS_PER_CYCLE(16)) dut16w (
    .clk(clk), .rst(rst), .start(start_v[2]), .a(a_v[2]), .b(b_v[2]), .bin(bin_v[2]),
    .busy(busy_v[2]), .done(done_v[2]), .diff(diff16w), .bout(bout_v[2]), .ovf(ovf_v[2]), .zero(zero_v[2])
  );

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_compared++;
    if (obs !== exp) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: integer arithmetic on w-bit operands.
  function automatic exp_t model(input int w, input logic [15:0] a, input logic [15:0] b, input logic bin);
    exp_t e;
    int mask, ai, bi, di, sa, sb, sd;
    mask   = (1 << w) - 1;
    ai     = int'(a) & mask;
    bi     = int'(b) & mask;
    di     = (ai - bi - int'(bin)) & mask;
    sa     = (ai >> (w - 1)) & 1;
    sb     = (bi >> (w - 1)) & 1;
    sd     = (di >> (w - 1)) & 1;
    e.diff = 16'(di);
    e.bout = (ai < bi + int'(bin));
    e.ovf  = ((sa ^ sb) & (sa ^ sd)) != 0;
    e.zero = (di == 0);
    return e;
  endfunction

  function automatic int width_of(input int sel);
    return (sel == 0) ? 8 : 16;
  endfunction

  task automatic push_exp(input int sel, input exp_t e);
    case (sel)
      0:       q0.push_back(e);
      1:       q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  task automatic compare_result(input int sel, input exp_t e);
    check_output($sformatf("dut%0d_diff", sel), 32'(diff_v[sel]), 32'(e.diff));
    check_output($sformatf("dut%0d_bout", sel), 32'(bout_v[sel]), 32'(e.bout));
    check_output($sformatf("dut%0d_ovf", sel),  32'(ovf_v[sel]),  32'(e.ovf));
    check_output($sformatf("dut%0d_zero", sel), 32'(zero_v[sel]), 32'(e.zero));
  endtask

  // Pops an expectation whenever a DUT pulses done; a done with nothing pending is an error.
  always @(negedge clk) begin
    if (!rst) begin
      if (done_v[0]) begin
        if (q0.size() == 0) check_output("dut0_spurious_done", 32'd1, 32'd0);
        else compare_result(0, q0.pop_front());
      end
      if (done_v[1]) begin
        if (q1.size() == 0) check_output("dut1_spurious_done", 32'd1, 32'd0);
        else compare_result(1, q1.pop_front());
      end
      if (done_v[2]) begin
        if (q2.size() == 0) check_output("dut2_spurious_done", 32'd1, 32'd0);
        else compare_result(2, q2.pop_front());
      end
    end
  end

  // One operation; optionally pulses start with junk operands a few cycles into RUN.
  task automatic apply_stimulus(input int sel, input logic [15:0] a, input logic [15:0] b,
                                input logic bin, input int latency, input bit glitch);
    int edges;
    int busy_cnt;
    @(negedge clk);
    start_v[sel] = 1'b1;
    a_v[sel]     = a;
    b_v[sel]     = b;
    bin_v[sel]   = bin;
    push_exp(sel, model(width_of(sel), a, b, bin));
    @(negedge clk);
    start_v[sel] = 1'b0;
    a_v[sel]     = 16'($urandom);
    b_v[sel]     = 16'($urandom);
    bin_v[sel]   = 1'($urandom);
    edges    = 0;
    busy_cnt = 0;
    while (!done_v[sel] && edges < 64) begin
      if (busy_v[sel]) busy_cnt++;
      start_v[sel] = glitch && (edges == 3);
      @(negedge clk);
      edges++;
    end
    start_v[sel] = 1'b0;
    check_output($sformatf("dut%0d_latency", sel), 32'(edges), 32'(latency));
    check_output($sformatf("dut%0d_busy_cycles", sel), 32'(busy_cnt), 32'(latency));
    check_output($sformatf("dut%0d_busy_at_done", sel), 32'(busy_v[sel]), 32'd0);
    @(negedge clk);
    check_output($sformatf("dut%0d_done_pulse", sel), 32'(done_v[sel]), 32'd0);
  endtask

  initial begin
    int edges;
    int n_done;
    int done_at [3];
    for (int i = 0; i < 3; i++) begin
      a_v[i] = '0;
      b_v[i] = '0;
    end

    #12;
    check_output("rst_busy", 32'(busy_v[0]), 32'd0);
    check_output("rst_done", 32'(done_v[0]), 32'd0);
    check_output("rst_diff", 32'(diff_v[0]), 32'd0);
    check_output("rst_bout", 32'(bout_v[0]), 32'd0);
    check_output("rst_ovf",  32'(ovf_v[0]),  32'd0);
    check_output("rst_zero", 32'(zero_v[0]), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    apply_stimulus(0, 16'h05, 16'h03, 1'b0, 8, 1'b0);
    apply_stimulus(0, 16'h03, 16'h05, 1'b0, 8, 1'b0);
    apply_stimulus(0, 16'h80, 16'h01, 1'b0, 8, 1'b0);
    apply_stimulus(0, 16'h5A, 16'h5A, 1'b0, 8, 1'b0);

    // Reset four cycles into an operation, while the held result is zero=1.
    @(negedge clk);
    start_v[0] = 1'b1;
    a_v[0] = 16'h77;
    b_v[0] = 16'h11;
    bin_v[0] = 1'b0;
    @(negedge clk);
    start_v[0] = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    #1;
    check_output("midrst_busy", 32'(busy_v[0]), 32'd0);
    check_output("midrst_done", 32'(done_v[0]), 32'd0);
    check_output("midrst_zero", 32'(zero_v[0]), 32'd0);
    check_output("midrst_diff", 32'(diff_v[0]), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    n_done = 0;
    repeat (12) begin
      @(negedge clk);
      if (done_v[0]) n_done++;
    end
    check_output("midrst_no_done", 32'(n_done), 32'd0);

    apply_stimulus(0, 16'h00, 16'h00, 1'b1, 8, 1'b0);
    apply_stimulus(0, 16'hC3, 16'h4E, 1'b1, 8, 1'b1);

    // Start held high: back-to-back results every L+1 cycles.
    @(negedge clk);
    a_v[0] = 16'h10;
    b_v[0] = 16'h01;
    bin_v[0] = 1'b0;
    start_v[0] = 1'b1;
    for (int i = 0; i < 3; i++) push_exp(0, model(8, 16'h10, 16'h01, 1'b0));
    edges = 0;
    n_done = 0;
    while (n_done < 3 && edges < 100) begin
      @(negedge clk);
      edges++;
      if (done_v[0]) begin
        done_at[n_done] = edges;
        n_done++;
      end
    end
    start_v[0] = 1'b0;
    check_output("held_done_count", 32'(n_done), 32'd3);
    if (n_done == 3) begin
      check_output("held_period_1", 32'(done_at[1] - done_at[0]), 32'd9);
      check_output("held_period_2", 32'(done_at[2] - done_at[1]), 32'd9);
    end

    for (int i = 0; i < 4; i++) apply_stimulus(0, 16'($urandom), 16'($urandom), 1'($urandom), 8, 1'b0);

    apply_stimulus(1, 16'h1234, 16'h4321, 1'b0, 4, 1'b0);
    apply_stimulus(1, 16'h8000, 16'h0001, 1'b0, 4, 1'b1);
    apply_stimulus(2, 16'h1234, 16'h4321, 1'b0, 1, 1'b0);
    apply_stimulus(2, 16'hFFFF, 16'hFFFF, 1'b1, 1, 1'b0);

    repeat (20) @(negedge clk);
    check_output("pending_results", 32'(q0.size() + q1.size() + q2.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

// File: doc/serial_subtractor.md
# serial_subtractor

Parametrised multi-cycle subtractor computing `diff = a - b - bin` over `WIDTH` bits, `BITS_PER_CYCLE` bits per clock, LSB slice first. It generalises the single-bit half subtractor into a word-wide, borrow-chained, handshaked datapath. It serves as the shared subtraction engine for wider arithmetic and compare blocks, and `bin`/`bout` allow multi-word chaining.

## Interface
Parameters:
- `WIDTH`, 8: operand and result width; must be ≥ 2.
- `BITS_PER_CYCLE`, 1: bits processed per cycle; must divide `WIDTH`. Latency `L = WIDTH/BITS_PER_CYCLE`.

Ports:
- `clk`, input, 1: single clock, rising edge.
- `rst`, input, 1: asynchronous, active-high reset.
- `start`, input, 1: request; sampled only when `busy`=0.
- `a`, input, `WIDTH`: minuend; captured on accepted start.
- `b`, input, `WIDTH`: subtrahend; captured on accepted start.
- `bin`, input, 1: borrow-in to bit 0; captured on accepted start.
- `busy`, output, 1: operation in progress.
- `done`, output, 1: one-cycle pulse; results valid.
- `diff`, output, `WIDTH`: result `a - b - bin` mod 2^`WIDTH`.
- `bout`, output, 1: borrow out of the MSB (unsigned `a < b + bin`).
- `ovf`, output, 1: two's-complement overflow.
- `zero`, output, 1: `diff` == 0.

## Operation
- States: `IDLE` and `RUN`.
- `IDLE`, `start`=1 at an edge:
  - latch `a`, `b`, `bin` into operand registers;
  - slice counter ← 0, borrow register ← `bin`;
  - go to `RUN`; `busy` ← 1.
- `RUN`, each edge:
  - one full-subtractor slice of `BITS_PER_CYCLE` bits, using the operand LSB slice and the borrow register;
  - slice result shifted into the top of the partial-diff register;
  - operand registers shift right by `BITS_PER_CYCLE`;
  - borrow register ← slice borrow-out;
  - counter increments.
- At the edge processing slice `L-1`:
  - `diff` ← full partial result;
  - `bout` ← final borrow;
  - `ovf` ← (a[MSB]^b[MSB]) & (a[MSB]^diff[MSB]), using the captured operands;
  - `zero` ← (diff == 0);
  - `done` ← 1, `busy` ← 0, state ← `IDLE`.
- Bit rule per bit: d = x^y^c; borrow = (~x&y) | (~(x^y)&c).
- `diff`, `bout`, `ovf` and `zero` update only on the `done` edge and hold until the next `done`. They never show partial values.
- `start` while `busy`=1 is ignored. The operation is not restarted, and input changes during `RUN` have no effect.
- `rst` asserted at any time, including mid-operation:
  - immediately forces `IDLE`;
  - all outputs 0, internal registers 0;
  - the in-flight operation is discarded and no `done` is produced.

## Timing
- Reset values: `busy`=0, `done`=0, `diff`=0, `bout`=0, `ovf`=0, `zero`=0.
  - `zero` resets to 0 even though `diff`=0; it means "valid result is zero".
- Start accepted at edge E0:
  - `busy`=1 from after E0;
  - slices are processed at edges E1…EL;
  - after EL: `done`=1, `busy`=0, results valid.
- `done` falls after EL+1 unless a new operation completes then. That cannot happen when L ≥ 1, because any operation takes L edges.
- `start` high in the `done` cycle is accepted at EL+1. Maximum throughput is one result per L+1 cycles.
- `start` held continuously high yields back-to-back operations with period L+1.
- `BITS_PER_CYCLE` = `WIDTH` gives L=1: result one edge after acceptance.

## Structure
- Package `sub_pkg`:
  - state enum {`IDLE`, `RUN`};
  - counter width function `$clog2(WIDTH/BITS_PER_CYCLE + 1)`.
- Sub-module `full_sub_slice`:
  - parameter `N`;
  - combinational N-bit ripple full subtractor with ports x, y, c_in, d, c_out;
  - instantiated once with N = `BITS_PER_CYCLE`.
- Top level holds the FSM, counter, shift registers and result registers.

## Test plan
- WIDTH=8, B=1, a=0x05, b=0x03, bin=0: `done` exactly 8 edges after acceptance. Expect diff=0x02, bout=0, ovf=0, zero=0; `busy` high for 8 cycles.
- a=0x03, b=0x05: expect diff=0xFE, bout=1, ovf=0. Then a=0x80, b=0x01: expect diff=0x7F, bout=0, ovf=1.
- a=b=0x5A: expect diff=0x00, zero=1. Then a=0x00, b=0x00, bin=1: expect diff=0xFF, bout=1, zero=0.
- Pulse `start` with new operands mid-`RUN`: the result matches the first operands and no extra `done` occurs. `start` held high gives `done` every 9 cycles.
- Assert `rst` 4 cycles into an operation: all outputs 0 at once and no `done`. A fresh start after release completes normally.
- WIDTH=16, B=4: a=0x1234, b=0x4321 gives diff=0xCF13, bout=1, with `done` 4 edges after acceptance. B=16 gives `done` 1 edge after acceptance.
